// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if: per-drive SD request bundle plus host SD channel signals.
interface sd_req_arbiter_if #(parameter int NUM_CH = 3);
  logic [NUM_CH-1:0]    ch_rd, ch_wr, ch_ack, ch_buff_wr;
  logic [32*NUM_CH-1:0] ch_lba;
  logic [8*NUM_CH-1:0]  ch_buff_din;
  logic                 sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, timeout_err;
  logic [31:0]          sd_lba;
  logic [7:0]           sd_buff_din;
  logic [1:0]           grant;
  modport slave (
    input  ch_rd, ch_wr, ch_lba, ch_buff_din, sd_ack, sd_buff_wr,
    output ch_ack, ch_buff_wr, sd_rd, sd_wr, sd_lba, sd_buff_din, grant, busy, timeout_err
  );
  modport master (
    output ch_rd, ch_wr, ch_lba, ch_buff_din, sd_ack, sd_buff_wr,
    input  ch_ack, ch_buff_wr, sd_rd, sd_wr, sd_lba, sd_buff_din, grant, busy, timeout_err
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin mux of per-drive SD block requests onto one host channel.
// Optional watchdog abort enabled by defining SD_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = 1048576
) (
  input logic             clk_sys,
  input logic             reset_n,
  sd_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t      r_state, w_state;
  logic [1:0]  r_last, w_last, r_grant, w_grant, w_sel, w_idx;
  logic        r_rd, w_rd, r_wr, w_wr, r_ack_d, w_found, w_tmo, w_act;
  logic [31:0] r_lba, w_lba;
  logic [3:0]  w_rd4, w_wr4, w_pend4, w_ack4, w_bwr4;
  assign w_rd4   = 4'(bus.ch_rd);
  assign w_wr4   = 4'(bus.ch_wr);
  assign w_pend4 = w_rd4 | w_wr4;
  assign w_act   = r_state == REQ || r_state == XFER;
  // Search begins one past the last served channel so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_idx   = 2'd0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = 2'((int'(r_last) + k) % NUM_CH);
      if (!w_found && w_pend4[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end
`ifdef SD_ARB_TIMEOUT_EN
  logic [20:0] r_cnt;
  logic        r_tmo;
  assign w_tmo = w_act && r_cnt == 21'(TIMEOUT - 1);
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE && w_found) ? '0 : w_act ? r_cnt + 21'd1 : r_cnt;
      r_tmo <= w_tmo;
    end
  assign bus.timeout_err = r_tmo;
`else
  assign w_tmo           = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_grant = r_grant;
    w_rd    = r_rd;
    w_wr    = r_wr;
    w_lba   = r_lba;
    case (r_state)
      IDLE: if (w_found) begin
        w_state = REQ;
        w_grant = w_sel;
        w_lba   = bus.ch_lba[{w_sel, 5'b0} +: 32];
        w_rd    = w_rd4[w_sel];
        w_wr    = !w_rd4[w_sel] && w_wr4[w_sel];
      end
      REQ: if (bus.sd_ack && !r_ack_d) begin
        w_state = XFER;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
      end
      XFER: w_state = (!bus.sd_ack && r_ack_d) ? DONE : XFER;
      default: begin
        w_state = IDLE;
        w_last  = r_grant;
      end
    endcase
    if (w_tmo) begin
      w_state = DONE;
      w_rd    = 1'b0;
      w_wr    = 1'b0;
    end
  end
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= 2'(NUM_CH - 1);
      r_grant <= 2'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_lba   <= '0;
      r_ack_d <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_grant <= w_grant;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_lba   <= w_lba;
      r_ack_d <= bus.sd_ack;
    end
  assign w_ack4          = 4'(bus.sd_ack) << r_grant;
  assign w_bwr4          = 4'(bus.sd_buff_wr) << r_grant;
  assign bus.ch_ack      = w_act ? NUM_CH'(w_ack4) : '0;
  assign bus.ch_buff_wr  = w_act ? NUM_CH'(w_bwr4) : '0;
  assign bus.sd_buff_din = bus.ch_buff_din[{r_grant, 3'b0} +: 8];
  assign bus.sd_rd       = r_rd;
  assign bus.sd_wr       = r_wr;
  assign bus.sd_lba      = r_lba;
  assign bus.grant       = r_grant;
  assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter: directed checks of arbitration, routing, reset and optional watchdog.
module tb_sd_req_arbiter;
  logic clk_sys = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  sd_req_arbiter_if #(.NUM_CH(3)) bus ();
  sd_req_arbiter #(.NUM_CH(3), .TIMEOUT(100)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
  always #5 clk_sys = ~clk_sys;
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rr_xfer(input int g);
    tick();
    chk("rr_grant", 32'(bus.grant), 32'(g));
    chk("rr_sd_rd", 32'(bus.sd_rd), 32'd1);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_rd[g] = 1'b0;
    chk("rr_rd_clr", 32'(bus.sd_rd), 32'd0);
    bus.sd_ack = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    reset_n = 1'b0;
    bus.ch_rd = '0; bus.ch_wr = '0; bus.ch_lba = '0; bus.ch_buff_din = '0;
    bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0;
    tick(); tick();
    chk("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
    chk("rst_sd_lba", bus.sd_lba, 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
    reset_n = 1'b1;
    tick();
    // single read on channel 1 with a 600-cycle ack window
    bus.ch_rd = 3'b010;
    bus.ch_lba[63:32] = 32'h1234;
    tick();
    chk("rd_sd_rd", 32'(bus.sd_rd), 32'd1);
    chk("rd_sd_wr", 32'(bus.sd_wr), 32'd0);
    chk("rd_lba", bus.sd_lba, 32'h1234);
    chk("rd_grant", 32'(bus.grant), 32'd1);
    chk("rd_busy", 32'(bus.busy), 32'd1);
    bus.sd_ack = 1'b1;
    #1 chk("rd_ack0", 32'(bus.ch_ack), 32'b010);
    for (int i = 0; i < 600; i++) begin
      tick();
      if (i == 0) begin
        chk("rd_clr", 32'(bus.sd_rd), 32'd0);
        bus.ch_rd = '0;
      end
      chk("rd_ack_win", 32'(bus.ch_ack), 32'b010);
    end
    bus.sd_ack = 1'b0;
    tick();
    chk("rd_busy_done", 32'(bus.busy), 32'd1);
    tick();
    chk("rd_busy_idle", 32'(bus.busy), 32'd0);
    // spurious host strobes in IDLE
    bus.sd_ack = 1'b1; bus.sd_buff_wr = 1'b1;
    #1;
    chk("sp_ack", 32'(bus.ch_ack), 32'd0);
    chk("sp_bwr", 32'(bus.ch_buff_wr), 32'd0);
    tick();
    chk("sp_busy", 32'(bus.busy), 32'd0);
    bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0;
    tick();
    chk("sp_busy2", 32'(bus.busy), 32'd0);
    // round robin from reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.ch_rd = 3'b111;
    rr_xfer(0);
    rr_xfer(1);
    rr_xfer(2);
    bus.ch_rd = 3'b111;
    rr_xfer(0);
    bus.ch_rd = '0;
    // write data path on channel 2 (last=0, so 1 then 2 are searched)
    bus.ch_wr = 3'b100;
    bus.ch_buff_din = {8'hA5, 8'h00, 8'h00};
    tick();
    chk("wr_sd_wr", 32'(bus.sd_wr), 32'd1);
    chk("wr_sd_rd", 32'(bus.sd_rd), 32'd0);
    chk("wr_grant", 32'(bus.grant), 32'd2);
    chk("wr_din", 32'(bus.sd_buff_din), 32'hA5);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_wr = '0;
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("wr_bwr", 32'(bus.ch_buff_wr), 32'b100);
    chk("wr_ack", 32'(bus.ch_ack), 32'b100);
    bus.sd_buff_wr = 1'b0;
    #1 chk("wr_bwr_off", 32'(bus.ch_buff_wr), 32'd0);
    bus.sd_ack = 1'b0;
    tick(); tick();
    chk("wr_idle", 32'(bus.busy), 32'd0);
    // rd and wr together: read first, write stays pending
    bus.ch_rd = 3'b001; bus.ch_wr = 3'b001;
    bus.ch_lba[31:0] = 32'hCAFE0001;
    tick();
    chk("rw_rd", 32'(bus.sd_rd), 32'd1);
    chk("rw_wr", 32'(bus.sd_wr), 32'd0);
    chk("rw_grant", 32'(bus.grant), 32'd0);
    chk("rw_lba", bus.sd_lba, 32'hCAFE0001);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_rd = '0;
    bus.sd_ack = 1'b0;
    tick(); tick(); tick();
    chk("rw_wr2", 32'(bus.sd_wr), 32'd1);
    chk("rw_rd2", 32'(bus.sd_rd), 32'd0);
    chk("rw_grant2", 32'(bus.grant), 32'd0);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_wr = '0;
    bus.sd_ack = 1'b0;
    tick(); tick();
    // reset during XFER
    bus.ch_rd = 3'b010;
    tick();
    chk("rx_grant1", 32'(bus.grant), 32'd1);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_rd = '0;
    reset_n = 1'b0;
    tick();
    chk("rx_sd_rd", 32'(bus.sd_rd), 32'd0);
    chk("rx_grant", 32'(bus.grant), 32'd0);
    chk("rx_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    bus.sd_ack = 1'b0;
    bus.ch_rd = 3'b101;
    tick();
    chk("rx_regrant", 32'(bus.grant), 32'd0);
    chk("rx_sd_rd2", 32'(bus.sd_rd), 32'd1);
    bus.sd_ack = 1'b1;
    tick();
    bus.ch_rd = '0;
    bus.sd_ack = 1'b0;
    tick(); tick();
`ifdef SD_ARB_TIMEOUT_EN
    bus.ch_rd = 3'b010;
    tick();
    chk("to_grant", 32'(bus.grant), 32'd1);
    for (int i = 0; i < 99; i++) begin
      tick();
      chk("to_quiet", 32'(bus.timeout_err), 32'd0);
    end
    tick();
    chk("to_pulse", 32'(bus.timeout_err), 32'd1);
    chk("to_rd_drop", 32'(bus.sd_rd), 32'd0);
    tick();
    chk("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    tick();
    chk("to_regrant", 32'(bus.grant), 32'd1);
    chk("to_rd_again", 32'(bus.sd_rd), 32'd1);
    bus.ch_rd = '0;
`else
    bus.ch_rd = 3'b010;
    for (int i = 0; i < 150; i++) tick();
    chk("nt_wait_rd", 32'(bus.sd_rd), 32'd1);
    chk("nt_tmo", 32'(bus.timeout_err), 32'd0);
    bus.ch_rd = '0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
